// File: rtl/fourinput_anf_recombine_stage.sv
// Two-stage masked ANF recombination for a 4-input Boolean function.
// Shares are evaluated in separate cones and refreshed with fresh randomness.
module fourinput_anf_recombine_stage #(
    parameter int unsigned NUM_OUT = 4,
    parameter logic [15:0] COEF0   = 16'h0000,
    parameter logic [15:0] COEF1   = 16'h0000,
    parameter logic [15:0] COEF2   = 16'h0000,
    parameter logic [15:0] COEF3   = 16'h0000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [14:0]        mono_share1,
    input  logic [14:0]        mono_share2,
    input  logic [NUM_OUT-1:0] rand_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] f_share1,
    output logic [NUM_OUT-1:0] f_share2,
    output logic [CNT_W-1:0]   eval_count
);

    localparam int unsigned MONO_W = 15;
    localparam logic [63:0] COEF_ALL = {COEF3, COEF2, COEF1, COEF0};

    logic               s1_valid;
    logic [MONO_W-1:0]  s1_mono_share1;
    logic [MONO_W-1:0]  s1_mono_share2;
    logic [NUM_OUT-1:0] s1_rand;
    logic [NUM_OUT-1:0] acc1;
    logic [NUM_OUT-1:0] acc2;
    logic               in_xfer;
    logic               s2_load;

    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign in_xfer  = in_valid & in_ready;

    // Per-coordinate XOR-sums; the constant term lands in share1 only.
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_coord
        localparam logic [15:0] C = COEF_ALL[16*i +: 16];
        assign acc1[i] = (^(C[15:1] & s1_mono_share1)) ^ C[0];
        assign acc2[i] = ^(C[15:1] & s1_mono_share2);
    end

    // Stage 1: capture the shared bundle and its refresh bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_mono_share1 <= '0;
            s1_mono_share2 <= '0;
            s1_rand        <= '0;
        end else if (in_xfer) begin
            s1_valid       <= 1'b1;
            s1_mono_share1 <= mono_share1;
            s1_mono_share2 <= mono_share2;
            s1_rand        <= rand_in;
        end else if (s2_load) begin
            s1_valid       <= 1'b0;
        end
    end

    // Stage 2: refreshed outputs, held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f_share1  <= '0;
            f_share2  <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            f_share1  <= acc1 ^ s1_rand;
            f_share2  <= acc2 ^ s1_rand;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_count <= '0;
        end else if (out_valid & out_ready) begin
            eval_count <= eval_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fourinput_anf_recombine_stage.sv
// Bench for fourinput_anf_recombine_stage configured as the PRESENT S-box;
// results are scored against the S-box table and its ANF derived here.
module tb_fourinput_anf_recombine_stage;

    localparam int unsigned NUM_OUT = 4;
    localparam int unsigned CNT_W   = 4;

    function automatic logic [3:0] sbox(input int v);
        case (v & 15)
            0: return 4'hC;  1: return 4'h5;  2: return 4'h6;  3: return 4'hB;
            4: return 4'h9;  5: return 4'h0;  6: return 4'hA;  7: return 4'hD;
            8: return 4'h3;  9: return 4'hE;  10: return 4'hF; 11: return 4'h8;
            12: return 4'h4; 13: return 4'h7; 14: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    // Coefficient position of the monomial whose variable set is u (bit0=x .. bit3=w).
    function automatic int mpos(input int u);
        case (u & 15)
            0: return 0;   1: return 1;   2: return 2;   4: return 3;
            8: return 4;   3: return 5;   5: return 6;   9: return 7;
            6: return 8;   10: return 9;  12: return 10; 7: return 11;
            11: return 12; 13: return 13; 14: return 14; default: return 15;
        endcase
    endfunction

    // Moebius transform of one output bit of the S-box truth table.
    function automatic logic [15:0] anf_coef(input int b);
        logic [15:0] c;
        logic [3:0]  s;
        logic        a;
        c = '0;
        for (int u = 0; u < 16; u++) begin
            a = 1'b0;
            for (int v = 0; v < 16; v++) begin
                s = sbox(v);
                if ((v & ~u & 15) == 0) a = a ^ s[b];
            end
            c[mpos(u)] = a;
        end
        return c;
    endfunction

    function automatic logic [14:0] mono_of(input logic [3:0] x);
        logic [14:0] m;
        m = '0;
        for (int u = 1; u < 16; u++)
            m[mpos(u)-1] = ((int'(x) & u) == u);
        return m;
    endfunction

    localparam logic [15:0] C0 = anf_coef(0);
    localparam logic [15:0] C1 = anf_coef(1);
    localparam logic [15:0] C2 = anf_coef(2);
    localparam logic [15:0] C3 = anf_coef(3);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [14:0]        mono_share1;
    logic [14:0]        mono_share2;
    logic [NUM_OUT-1:0] rand_in;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OUT-1:0] f_share1;
    logic [NUM_OUT-1:0] f_share2;
    logic [CNT_W-1:0]   eval_count;

    fourinput_anf_recombine_stage #(
        .NUM_OUT(NUM_OUT), .COEF0(C0), .COEF1(C1), .COEF2(C2), .COEF3(C3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mono_share1(mono_share1), .mono_share2(mono_share2), .rand_in(rand_in),
        .out_valid(out_valid), .out_ready(out_ready), .f_share1(f_share1),
        .f_share2(f_share2), .eval_count(eval_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] f1;
        logic [3:0] f2;
        logic [3:0] x;
        int         t;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          step_idx = 0;
    int          n_out    = 0;
    logic [3:0]  exp_cnt  = '0;
    logic        lat_check = 1'b1;
    logic        last_acc;
    logic        stalled_prev = 1'b0;
    logic [3:0]  prev_f1, prev_f2;
    logic [15:0] seen1 [16];
    logic [15:0] seen2 [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, got, exp, step_idx);
        end
    endtask

    // Expected shares: share2 from the ANF applied to its own monomial shares,
    // share1 so that the two recombine to the S-box value.
    function automatic exp_t model(input logic [3:0] x, input logic [14:0] m2, input logic [3:0] r);
        exp_t        e;
        logic [15:0] cf [4];
        logic [3:0]  sv;
        cf[0] = C0; cf[1] = C1; cf[2] = C2; cf[3] = C3;
        sv = sbox(int'(x));
        for (int i = 0; i < 4; i++) begin
            e.f2[i] = r[i];
            for (int u = 1; u < 16; u++)
                if (cf[i][mpos(u)]) e.f2[i] = e.f2[i] ^ m2[mpos(u)-1];
            e.f1[i] = e.f2[i] ^ sv[i];
        end
        e.x = x;
        e.t = step_idx;
        return e;
    endfunction

    // One cycle: drive inputs at the falling edge, then score what the next rising edge will do.
    task automatic step(input logic iv, input logic [3:0] x, input logic ordy);
        logic [14:0] m2;
        logic [3:0]  r;
        exp_t        e;
        @(negedge clk);
        m2 = 15'($urandom);
        r  = 4'($urandom);
        in_valid    = iv;
        mono_share2 = m2;
        mono_share1 = mono_of(x) ^ m2;
        rand_in     = r;
        out_ready   = ordy;
        #1;
        if (stalled_prev) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_f1", 32'(f_share1), 32'(prev_f1));
            check_eq("stall_f2", 32'(f_share2), 32'(prev_f2));
        end
        check_eq("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !ordy)));
        check_eq("eval_count", 32'(eval_count), 32'(exp_cnt));
        if (q.size() == 0) check_eq("idle_out_valid", 32'(out_valid), 32'd0);
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            check_eq("recombined", 32'(f_share1 ^ f_share2), 32'(sbox(int'(e.x))));
            check_eq("f_share1", 32'(f_share1), 32'(e.f1));
            check_eq("f_share2", 32'(f_share2), 32'(e.f2));
            if (lat_check) check_eq("latency", 32'(step_idx - e.t), 32'd2);
            seen1[e.x][f_share1] = 1'b1;
            seen2[e.x][f_share2] = 1'b1;
            exp_cnt = exp_cnt + 4'd1;
            n_out++;
        end
        last_acc = in_valid && in_ready;
        if (last_acc) q.push_back(model(x, m2, r));
        stalled_prev = out_valid && !out_ready;
        prev_f1 = f_share1;
        prev_f2 = f_share2;
        step_idx++;
    endtask

    initial begin
        int sent;
        int base;
        logic [3:0] pat;
        for (int i = 0; i < 16; i++) begin seen1[i] = '0; seen2[i] = '0; end
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mono_share1 = '0; mono_share2 = '0; rand_in = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_f1", 32'(f_share1), 32'd0);
        check_eq("rst_f2", 32'(f_share2), 32'd0);
        check_eq("rst_count", 32'(eval_count), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Constant-term and single-variable inputs, then full sweep with re-randomised shares.
        step(1'b1, 4'd0, 1'b1);
        step(1'b1, 4'd1, 1'b1);
        repeat (3) step(1'b0, 4'd0, 1'b1);
        for (int rep = 0; rep < 6; rep++)
            for (int x = 0; x < 16; x++) step(1'b1, 4'(x), 1'b1);
        repeat (3) step(1'b0, 4'd0, 1'b1);
        check_eq("share1_varies", 32'($countones(seen1[7]) > 1), 32'd1);
        check_eq("share2_varies", 32'($countones(seen2[12]) > 1), 32'd1);

        // Backpressure: 8 bundles, out_ready pattern 1,0,0,1.
        lat_check = 1'b0;
        base = n_out; sent = 0; pat = 4'b1001;
        for (int k = 0; k < 80 && (sent < 8 || q.size() > 0); k++) begin
            step(sent < 8, 4'($urandom), pat[k % 4]);
            if (last_acc) sent++;
        end
        check_eq("bp_outputs", 32'(n_out - base), 32'd8);
        check_eq("bp_drained", 32'(q.size()), 32'd0);

        // Back-to-back throughput: 20 bundles, each out exactly two cycles later.
        lat_check = 1'b1;
        base = n_out;
        repeat (20) step(1'b1, 4'($urandom), 1'b1);
        repeat (3) step(1'b0, 4'd0, 1'b1);
        check_eq("tp_outputs", 32'(n_out - base), 32'd20);

        // Reset with both stages full.
        repeat (3) step(1'b1, 4'($urandom), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_f1", 32'(f_share1), 32'd0);
        check_eq("mid_rst_f2", 32'(f_share2), 32'd0);
        check_eq("mid_rst_count", 32'(eval_count), 32'd0);
        q.delete();
        exp_cnt = '0;
        stalled_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 4'd0, 1'b1);
        base = n_out;
        step(1'b1, 4'd9, 1'b1);
        repeat (3) step(1'b0, 4'd0, 1'b1);
        check_eq("post_rst_output", 32'(n_out - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
